div_seq: RTL and testbench



---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 26 ++
 rtl/div_seq.sv | 145 ++++++++++++++
 tb/tb_div_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
// Imported by div_step and div_seq.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_e;

  localparam int MIN_WIDTH = 4;

  // Every quotient bit is set on divide-by-zero
  localparam logic DBZ_Q_BIT = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
// Shifts {A,Q} left, trial-subtracts M and restores on a negative result.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH+1:0] w_sh;
  logic [WIDTH+1:0] w_diff;
  logic             w_neg;

  assign w_sh   = {i_a, i_q[WIDTH-1]};
  assign w_diff = w_sh - {2'b00, i_m};
  assign w_neg  = w_diff[WIDTH+1];

  assign o_a = w_neg ? w_sh[WIDTH:0] : w_diff[WIDTH:0];
  assign o_q = {i_q[WIDTH-2:0], ~w_neg};

endmodule

// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN to honour signed_op (two's-complement operands).
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_dbz_p;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_mag_n;
  logic [WIDTH-1:0] w_mag_d;
  logic [WIDTH-1:0] w_q_res;
  logic [WIDTH-1:0] w_r_res;
  logic             w_zero;
  logic             w_accept;

  assign w_zero   = (divisor == '0);
  assign w_accept = (r_state == IDLE) && start && !w_zero;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_a(r_a),
    .i_q(r_q),
    .i_m(r_m),
    .o_a(w_a_nxt),
    .o_q(w_q_nxt)
  );

`ifdef DIV_SIGNED_EN
  logic w_sa;
  logic w_sb;
  logic r_neg_q;
  logic r_neg_r;

  assign w_sa    = signed_op & dividend[WIDTH-1];
  assign w_sb    = signed_op & divisor[WIDTH-1];
  assign w_mag_n = w_sa ? -dividend : dividend;
  assign w_mag_d = w_sb ? -divisor : divisor;
  assign w_q_res = r_neg_q ? -r_q : r_q;
  assign w_r_res = r_neg_r ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];

  // Truncating division: quotient sign is the XOR, remainder follows the dividend
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_neg_q <= w_sa ^ w_sb;
      r_neg_r <= w_sa;
    end
  end
`else
  logic w_unused_sop;

  assign w_unused_sop = signed_op;
  assign w_mag_n      = dividend;
  assign w_mag_d      = divisor;
  assign w_q_res      = r_q;
  assign w_r_res      = r_a[WIDTH-1:0];
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_dbz_p <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
      q       <= '0;
      r       <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            dbz  <= 1'b0;
            if (w_zero) begin
              // Raw dividend is parked in Q so it can be returned as r
              r_dbz_p <= 1'b1;
              r_q     <= dividend;
              r_state <= FIX;
            end else begin
              r_dbz_p <= 1'b0;
              r_q     <= w_mag_n;
              r_m     <= w_mag_d;
              r_a     <= '0;
              r_cnt   <= CNT_W'(WIDTH);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          dbz     <= r_dbz_p;
          r_state <= IDLE;
          if (r_dbz_p) begin
            q <= {WIDTH{DBZ_Q_BIT}};
            r <= r_q;
          end else begin
            q <= w_q_res;
            r <= w_r_res;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and swept checks of div_seq at WIDTH=32 and WIDTH=8.
// A per-cycle scoreboard compares both instances against an arithmetic model.
module tb_div_seq;

`ifdef DIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        st = 1'b0;
  logic        sop = 1'b0;
  logic [31:0] nd = '0;
  logic [31:0] dv = '0;
  logic        busy, done, dbz;
  logic [31:0] q, r;

  logic        st8 = 1'b0;
  logic        sop8 = 1'b0;
  logic [7:0]  nd8 = '0;
  logic [7:0]  dv8 = '0;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) u32 (
    .clk(clk), .clr(clr), .start(st), .signed_op(sop),
    .dividend(nd), .divisor(dv),
    .busy(busy), .done(done), .dbz(dbz), .q(q), .r(r)
  );

  div_seq #(.WIDTH(8)) u8 (
    .clk(clk), .clr(clr), .start(st8), .signed_op(sop8),
    .dividend(nd8), .divisor(dv8),
    .busy(busy8), .done(done8), .dbz(dbz8), .q(q8), .r(r8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference division from the arithmetic definition
  function automatic void ref_div(input int w, input longint unsigned n,
                                  input longint unsigned d, input bit sg,
                                  output longint unsigned qo,
                                  output longint unsigned ro, output bit z);
    longint unsigned mask;
    longint sn, sd;
    mask = (64'd1 << w) - 64'd1;
    z = (d == 0);
    if (z) begin
      qo = mask;
      ro = n;
    end else if (!sg) begin
      qo = n / d;
      ro = n % d;
    end else begin
      sn = n[w-1] ? longint'(n) - longint'(64'd1 << w) : longint'(n);
      sd = d[w-1] ? longint'(d) - longint'(64'd1 << w) : longint'(d);
      qo = longint'(sn / sd) & mask;
      ro = longint'(sn % sd) & mask;
    end
  endfunction

  int              m_left[2] = '{0, 0};
  bit              e_done[2] = '{0, 0};
  bit              e_dbz[2]  = '{0, 0};
  longint unsigned e_q[2]    = '{0, 0};
  longint unsigned e_r[2]    = '{0, 0};
  bit              p_dbz[2]  = '{0, 0};
  longint unsigned p_q[2]    = '{0, 0};
  longint unsigned p_r[2]    = '{0, 0};

  task automatic mstep(input int k, input bit s, input bit sg,
                       input longint unsigned n, input longint unsigned d,
                       input int w);
    e_done[k] = 1'b0;
    if (m_left[k] > 0) begin
      m_left[k]--;
      if (m_left[k] == 0) begin
        e_done[k] = 1'b1;
        e_q[k]    = p_q[k];
        e_r[k]    = p_r[k];
        e_dbz[k]  = p_dbz[k];
      end
    end else if (s) begin
      ref_div(w, n, d, sg, p_q[k], p_r[k], p_dbz[k]);
      m_left[k] = (d == 0) ? 1 : w + 1;
    end
  endtask

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int k = 0; k < 2; k++) begin
        m_left[k] = 0;
        e_done[k] = 1'b0;
        e_dbz[k]  = 1'b0;
        e_q[k]    = 0;
        e_r[k]    = 0;
      end
    end else begin
      mstep(0, st, sop & SGN, longint'(nd), longint'(dv), 32);
      mstep(1, st8, 1'b0, longint'(nd8), longint'(dv8), 8);
    end
  end

  always @(negedge clk) begin
    chk("busy32", busy, m_left[0] > 0);
    chk("done32", done, e_done[0]);
    chk("q32", q, e_q[0]);
    chk("r32", r, e_r[0]);
    if (e_done[0]) chk("dbz32", dbz, e_dbz[0]);
    chk("busy8", busy8, m_left[1] > 0);
    chk("done8", done8, e_done[1]);
    chk("q8", q8, e_q[1]);
    chk("r8", r8, e_r[1]);
    if (e_done[1]) chk("dbz8", dbz8, e_dbz[1]);
  end

  task automatic kick(input logic [31:0] a, input logic [31:0] b, input bit s);
    st = 1'b1; sop = s; nd = a; dv = b;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    do begin
      @(negedge clk);
      st = 1'b0;
      n++;
      nb += int'(busy);
    end while (!done && n < 100);
  endtask

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s,
                       input int lat);
    int n, nb;
    @(negedge clk);
    kick(a, b, s);
    wait_done(n, nb);
    chk("latency32", n, lat);
  endtask

  logic [7:0] ta8[4] = '{8'd255, 8'd0, 8'd255, 8'd200};
  logic [7:0] tb8[4] = '{8'd1, 8'd255, 8'd128, 8'd13};

  initial begin
    int n, nb;
    logic [7:0] a8, b8;

    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst q", q, 0);
    clr = 1'b0;

    @(negedge clk);
    kick(32'd100, 32'd7, 1'b0);
    wait_done(n, nb);
    chk("100/7 latency", n, 34);
    chk("100/7 busy cycles", nb, 33);
    chk("100/7 q", q, 14);
    chk("100/7 r", r, 2);
    chk("100/7 dbz", dbz, 0);

    run32(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34);
    chk("msb q", q, 1);
    chk("msb r", r, 32'h7FFF_FFFF);

    run32(32'd5, 32'd0, 1'b0, 2);
    chk("dbz q", q, 32'hFFFF_FFFF);
    chk("dbz r", r, 5);
    chk("dbz flag", dbz, 1);

`ifdef DIV_SIGNED_EN
    run32(-32'sd7, 32'd2, 1'b1, 34);
    chk("-7/2 q", q, 32'hFFFF_FFFD);
    chk("-7/2 r", r, 32'hFFFF_FFFF);
    run32(32'd7, -32'sd2, 1'b1, 34);
    chk("7/-2 q", q, 32'hFFFF_FFFD);
    chk("7/-2 r", r, 1);
    run32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 34);
    chk("minneg q", q, 32'h8000_0000);
    chk("minneg r", r, 0);
    chk("minneg dbz", dbz, 0);
`else
    run32(-32'sd7, 32'd2, 1'b1, 34);
    chk("uns -7/2 q", q, 32'h7FFF_FFFC);
    chk("uns -7/2 r", r, 1);
`endif

    @(negedge clk);
    kick(32'd200, 32'd3, 1'b0);
    @(negedge clk);
    st = 1'b0;
    repeat (5) @(negedge clk);
    kick(32'd77, 32'd5, 1'b0);
    wait_done(n, nb);
    chk("ignored start q", q, 66);
    chk("ignored start r", r, 2);

    kick(32'd45, 32'd6, 1'b0);
    chk("b2b old q", q, 66);
    chk("b2b old r", r, 2);
    wait_done(n, nb);
    chk("b2b latency", n, 34);
    chk("b2b q", q, 7);
    chk("b2b r", r, 3);

    @(negedge clk);
    kick(32'd1000, 32'd7, 1'b0);
    @(negedge clk);
    st = 1'b0;
    repeat (9) @(negedge clk);
    #2 clr = 1'b1;
    #1;
    chk("clr busy", busy, 0);
    chk("clr done", done, 0);
    chk("clr q", q, 0);
    chk("clr r", r, 0);
    @(negedge clk);
    clr = 1'b0;
    run32(32'd1000, 32'd10, 1'b0, 34);
    chk("post-clr q", q, 100);
    chk("post-clr r", r, 0);

    for (int i = 0; i < 1000; i++) begin
      if (i < 4) begin
        a8 = ta8[i];
        b8 = tb8[i];
      end else begin
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(1, 255));
      end
      @(negedge clk);
      st8 = 1'b1; nd8 = a8; dv8 = b8;
      n = 0;
      do begin
        @(negedge clk);
        st8 = 1'b0;
        n++;
      end while (!done8 && n < 50);
      chk("latency8", n, 10);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
